// File: rtl/pc_fetch_pkg.sv
// Shared constants for the fetch PC sequencer: state encodings, PC width and default reset PC.
package pc_fetch_pkg;

    localparam int unsigned PC_W = 32;

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_PEND = 2'd2;

    localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/mini_ALU.sv
// Small two-operand ALU; the fetch sequencer uses opcode 2'b00 (add) as its PC incrementer.
module mini_ALU #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [1:0]       i_op,
    output logic [WIDTH-1:0] o_y
);

    always_comb begin
        case (i_op)
            2'b00: o_y = i_a + i_b;
            2'b01: o_y = i_a - i_b;
            2'b10: o_y = i_a & i_b;
            2'b11: o_y = i_a | i_b;
        endcase
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC sequencer: applies execute redirects, holds on stall/back-pressure, flushes F/D, D/X.
// Define PC_FETCH_PERF_EN to build the saturating redirect counter.
module pc_fetch_ctrl
    import pc_fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned     CNT_W    = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_ctrl,
    input  logic [PC_W-1:0]  jump_address,
    input  logic             imem_ready,
    output logic [PC_W-1:0]  pc_f,
    output logic [PC_W-1:0]  fd_pc,
    output logic             fd_valid,
    output logic             flush_fd,
    output logic             flush_dx,
    output logic [CNT_W-1:0] redirect_count
);

    logic [1:0]      r_state, w_state_nxt;
    logic [PC_W-1:0] r_pc, w_pc_nxt;
    logic [PC_W-1:0] r_fd_pc, w_fd_pc_nxt;
    logic [PC_W-1:0] r_pend_pc, w_pend_pc_nxt;
    logic [PC_W-1:0] w_pc_inc;
    logic            r_fd_valid, w_fd_valid_nxt;

    mini_ALU #(
        .WIDTH (PC_W)
    ) u_pc_inc (
        .i_a  (r_pc),
        .i_b  ({{(PC_W-1){1'b0}}, 1'b1}),
        .i_op (2'b00),
        .o_y  (w_pc_inc)
    );

    // Priority: new redirect, buffered redirect, stall, back-pressure, sequential.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_fd_pc_nxt    = r_fd_pc;
        w_fd_valid_nxt = r_fd_valid;
        w_pend_pc_nxt  = r_pend_pc;
        if (branch_ctrl) begin
            w_fd_valid_nxt = 1'b0;
            if (imem_ready) begin
                w_pc_nxt    = jump_address;
                w_state_nxt = ST_RUN;
            end else begin
                w_pend_pc_nxt = jump_address;
                w_state_nxt   = ST_PEND;
            end
        end else if (r_state == ST_PEND) begin
            w_fd_valid_nxt = 1'b0;
            if (imem_ready) begin
                w_pc_nxt    = r_pend_pc;
                w_state_nxt = ST_RUN;
            end
        end else if (!stall) begin
            if (!imem_ready) begin
                w_fd_valid_nxt = 1'b0;
                w_state_nxt    = ST_HOLD;
            end else begin
                w_pc_nxt       = w_pc_inc;
                w_fd_pc_nxt    = r_pc;
                w_fd_valid_nxt = 1'b1;
                w_state_nxt    = ST_RUN;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_RUN;
            r_pc       <= RESET_PC;
            r_fd_pc    <= '0;
            r_fd_valid <= 1'b0;
            r_pend_pc  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_fd_pc    <= w_fd_pc_nxt;
            r_fd_valid <= w_fd_valid_nxt;
            r_pend_pc  <= w_pend_pc_nxt;
        end
    end

    assign pc_f     = r_pc;
    assign fd_pc    = r_fd_pc;
    assign fd_valid = r_fd_valid;
    // F/D stays poisoned while a redirect waits for the instruction memory.
    assign flush_fd = branch_ctrl | (r_state == ST_PEND);
    assign flush_dx = branch_ctrl;

`ifdef PC_FETCH_PERF_EN
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (branch_ctrl && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign redirect_count = r_cnt;
`else
    assign redirect_count = '0;
`endif

endmodule
